// File: rtl/virtio_sched_pkg.sv
// Shared types and helpers for the virtio notification scheduler.
//   DEFAULT_NUM_Q : default number of virtqueues
//   qid_width()   : width of a queue index, never less than one bit
//   sched_state_t : scheduler FSM states
package virtio_sched_pkg;

    localparam int DEFAULT_NUM_Q = 3;

    function automatic int qid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/virtio_notify_sched_if.sv
// Grant/completion bus between the notify scheduler and the ring-fetch engine.
//   svc_valid/svc_qid : grant offered by the scheduler
//   svc_ready         : fetch engine accepts the grant
//   svc_done/svc_more : service finished; avail ring still non-empty
// Modports: master = scheduler side, slave = fetch-engine side.
interface virtio_notify_sched_if
    import virtio_sched_pkg::*;
#(
    parameter int NUM_Q = DEFAULT_NUM_Q,
    parameter int QID_W = qid_width(NUM_Q)
) ();

    logic             svc_valid;
    logic [QID_W-1:0] svc_qid;
    logic             svc_ready;
    logic             svc_done;
    logic             svc_more;

    modport master (
        output svc_valid, svc_qid,
        input  svc_ready, svc_done, svc_more
    );

    modport slave (
        input  svc_valid, svc_qid,
        output svc_ready, svc_done, svc_more
    );

endinterface

// File: rtl/virtio_rr_arb.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per queue
//   last    : index granted most recently; search begins at last+1
//   gnt_vld : some request is set
//   gnt_idx : winning index (0 when gnt_vld is low)
module virtio_rr_arb
    import virtio_sched_pkg::*;
#(
    parameter int NUM_Q = DEFAULT_NUM_Q,
    parameter int QID_W = qid_width(NUM_Q)
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [QID_W-1:0] last,
    output logic             gnt_vld,
    output logic [QID_W-1:0] gnt_idx
);

    always_comb begin
        automatic int idx = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        // Offsets 1..NUM_Q visit every queue once, ending on `last` itself.
        for (int k = 1; k <= NUM_Q; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_Q) begin
                idx = idx - NUM_Q;
            end
            if (!gnt_vld && req[QID_W'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = QID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/virtio_notify_sched.sv
// Per-virtqueue notification scheduler.
// Latches queue-notify doorbells as pending bits, picks one eligible queue
// round-robin and offers it to the fetch engine; only one grant is ever
// outstanding, and the next is offered only after svc_done.
//   clk, rst_n        : clock, asynchronous active-low reset
//   driver_ok         : device live; low clears all pending bits
//   queue_enable      : per-queue enable (gates eligibility only)
//   queue_notify_set  : per-queue doorbell pulse
//   queue_reset       : per-queue reset pulse
//   svc               : grant/completion bus (master side)
//   pending           : pending bits
//   busy              : grant offered or being serviced
//   coalesced_cnt     : saturating count of notifies to already-pending queues
module virtio_notify_sched
    import virtio_sched_pkg::*;
#(
    parameter int NUM_Q = DEFAULT_NUM_Q,
    parameter int CNT_W = 32,
    localparam int QID_W = qid_width(NUM_Q)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  driver_ok,
    input  logic [NUM_Q-1:0]      queue_enable,
    input  logic [NUM_Q-1:0]      queue_notify_set,
    input  logic [NUM_Q-1:0]      queue_reset,
    virtio_notify_sched_if.master svc,
    output logic [NUM_Q-1:0]      pending,
    output logic                  busy,
    output logic [CNT_W-1:0]      coalesced_cnt
);

    sched_state_t     state_reg, state_next;
    logic             valid_reg, valid_next;
    logic [QID_W-1:0] qid_reg, qid_next;
    logic [QID_W-1:0] last_reg, last_next;
    logic [NUM_Q-1:0] pending_reg, pending_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [NUM_Q-1:0] eligible;
    logic             gnt_vld;
    logic [QID_W-1:0] gnt_idx;
    logic             accept;
    logic             done_evt;

    assign eligible = pending_reg & queue_enable & {NUM_Q{driver_ok}};
    assign accept   = (state_reg == GRANT) && valid_reg && svc.svc_ready;
    // Completions are only meaningful while a service is in flight.
    assign done_evt = (state_reg == BUSY) && svc.svc_done;

    virtio_rr_arb #(
        .NUM_Q (NUM_Q),
        .QID_W (QID_W)
    ) u_arb (
        .req     (eligible),
        .last    (last_reg),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Pending update, highest priority first. A doorbell beats the
    // acceptance clear so a notify racing the grant is never lost.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_Q; gi++) begin : g_pend
            logic rearm;
            logic taken;
            assign rearm = done_evt && svc.svc_more && (qid_reg == QID_W'(gi));
            assign taken = accept && (qid_reg == QID_W'(gi));
            assign pending_next[gi] = !driver_ok           ? 1'b0 :
                                      queue_reset[gi]      ? 1'b0 :
                                      queue_notify_set[gi] ? 1'b1 :
                                      rearm                ? 1'b1 :
                                      taken                ? 1'b0 :
                                                             pending_reg[gi];
        end
    endgenerate

    // One increment per coalesced doorbell this cycle, sticking at all-ones.
    always_comb begin
        cnt_next = cnt_reg;
        for (int i = 0; i < NUM_Q; i++) begin
            if (queue_notify_set[i] && pending_reg[i] && (cnt_next != '1)) begin
                cnt_next = cnt_next + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        qid_next   = qid_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (gnt_vld) begin
                    qid_next   = gnt_idx;
                    valid_next = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // A handshake that completes takes precedence over a
                // same-cycle withdraw: the engine has already taken the queue.
                if (svc.svc_ready) begin
                    valid_next = 1'b0;
                    last_next  = qid_reg;
                    state_next = BUSY;
                end else if (!driver_ok || queue_reset[qid_reg]) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (svc.svc_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            valid_reg   <= 1'b0;
            qid_reg     <= '0;
            last_reg    <= QID_W'(NUM_Q - 1);
            pending_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            valid_reg   <= valid_next;
            qid_reg     <= qid_next;
            last_reg    <= last_next;
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign svc.svc_valid = valid_reg;
    assign svc.svc_qid   = qid_reg;
    assign pending       = pending_reg;
    assign busy          = (state_reg != IDLE);
    assign coalesced_cnt = cnt_reg;

endmodule

// File: tb/tb_virtio_notify_sched.sv
// Self-checking bench for virtio_notify_sched (NUM_Q=3, CNT_W=32).
// Table vectors drive one cycle each and check the registered outputs just
// after the clock edge; hand sequences cover driver_ok loss, async reset and
// round-robin fairness.
module tb_virtio_notify_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        driver_ok = 1'b0;
    logic [2:0]  queue_enable = 3'b000;
    logic [2:0]  queue_notify_set = 3'b000;
    logic [2:0]  queue_reset = 3'b000;
    logic [2:0]  pending;
    logic        busy;
    logic [31:0] coalesced_cnt;

    int total = 0;
    int bad = 0;

    virtio_notify_sched_if #(.NUM_Q(3)) sif ();

    virtio_notify_sched #(
        .NUM_Q (3),
        .CNT_W (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .driver_ok        (driver_ok),
        .queue_enable     (queue_enable),
        .queue_notify_set (queue_notify_set),
        .queue_reset      (queue_reset),
        .svc              (sif.master),
        .pending          (pending),
        .busy             (busy),
        .coalesced_cnt    (coalesced_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  en;
        logic [2:0]  ntf;
        logic [2:0]  qrst;
        logic        rdy;
        logic        done;
        logic        more;
        logic        ev;
        logic [1:0]  eq;
        logic [2:0]  ep;
        logic        eb;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl[37];

    function automatic vec_t mk(input logic [2:0] en, input logic [2:0] ntf,
                                input logic [2:0] qrst, input logic rdy,
                                input logic done, input logic more,
                                input logic ev, input logic [1:0] eq,
                                input logic [2:0] ep, input logic eb,
                                input logic [31:0] ec);
        vec_t v;
        v.en = en; v.ntf = ntf; v.qrst = qrst; v.rdy = rdy; v.done = done;
        v.more = more; v.ev = ev; v.eq = eq; v.ep = ep; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic step(input logic dok, input logic [2:0] en, input logic [2:0] ntf,
                        input logic [2:0] qrst, input logic rdy, input logic done,
                        input logic more);
        @(negedge clk);
        driver_ok        = dok;
        queue_enable     = en;
        queue_notify_set = ntf;
        queue_reset      = qrst;
        sif.svc_ready    = rdy;
        sif.svc_done     = done;
        sif.svc_more     = more;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {valid, qid, pending, busy, cnt} packed into one value for compact checks.
    function automatic logic [63:0] snap();
        return {25'd0, sif.svc_valid, sif.svc_qid, pending, busy, coalesced_cnt};
    endfunction

    function automatic logic [63:0] want(input logic ev, input logic [1:0] eq,
                                         input logic [2:0] ep, input logic eb,
                                         input logic [31:0] ec);
        return {25'd0, ev, eq, ep, eb, ec};
    endfunction

    initial begin
        //            en    ntf   qrst  r  d  m    v  qid pend  b  cnt
        tbl[0]  = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   0, 0, 3'd0, 0, 0);
        tbl[1]  = mk(3'd7, 3'd2, 3'd0, 0, 0, 0,   0, 0, 3'd2, 0, 0);
        tbl[2]  = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   1, 1, 3'd2, 1, 0);
        tbl[3]  = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   1, 1, 3'd2, 1, 0);
        tbl[4]  = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   1, 1, 3'd2, 1, 0);
        tbl[5]  = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   1, 1, 3'd2, 1, 0);
        tbl[6]  = mk(3'd7, 3'd0, 3'd0, 1, 0, 0,   0, 1, 3'd0, 1, 0);
        tbl[7]  = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   0, 1, 3'd0, 1, 0);
        tbl[8]  = mk(3'd7, 3'd0, 3'd0, 0, 1, 0,   0, 1, 3'd0, 0, 0);
        tbl[9]  = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   0, 1, 3'd0, 0, 0);
        tbl[10] = mk(3'd7, 3'd4, 3'd0, 0, 0, 0,   0, 1, 3'd4, 0, 0);
        tbl[11] = mk(3'd7, 3'd4, 3'd0, 0, 0, 0,   1, 2, 3'd4, 1, 1);
        tbl[12] = mk(3'd7, 3'd4, 3'd0, 0, 0, 0,   1, 2, 3'd4, 1, 2);
        tbl[13] = mk(3'd7, 3'd0, 3'd0, 1, 0, 0,   0, 2, 3'd0, 1, 2);
        tbl[14] = mk(3'd7, 3'd0, 3'd0, 0, 1, 0,   0, 2, 3'd0, 0, 2);
        tbl[15] = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   0, 2, 3'd0, 0, 2);
        tbl[16] = mk(3'd7, 3'd1, 3'd0, 0, 0, 0,   0, 2, 3'd1, 0, 2);
        tbl[17] = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   1, 0, 3'd1, 1, 2);
        tbl[18] = mk(3'd7, 3'd0, 3'd0, 1, 0, 0,   0, 0, 3'd0, 1, 2);
        tbl[19] = mk(3'd7, 3'd1, 3'd0, 0, 0, 0,   0, 0, 3'd1, 1, 2);
        tbl[20] = mk(3'd7, 3'd0, 3'd0, 0, 1, 0,   0, 0, 3'd1, 0, 2);
        tbl[21] = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   1, 0, 3'd1, 1, 2);
        tbl[22] = mk(3'd7, 3'd0, 3'd0, 1, 0, 0,   0, 0, 3'd0, 1, 2);
        tbl[23] = mk(3'd7, 3'd0, 3'd0, 0, 1, 1,   0, 0, 3'd1, 0, 2);
        tbl[24] = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   1, 0, 3'd1, 1, 2);
        tbl[25] = mk(3'd7, 3'd1, 3'd0, 1, 0, 0,   0, 0, 3'd1, 1, 3);
        tbl[26] = mk(3'd7, 3'd0, 3'd0, 0, 1, 0,   0, 0, 3'd1, 0, 3);
        tbl[27] = mk(3'd7, 3'd0, 3'd0, 1, 0, 0,   1, 0, 3'd1, 1, 3);
        tbl[28] = mk(3'd7, 3'd0, 3'd0, 1, 0, 0,   0, 0, 3'd0, 1, 3);
        tbl[29] = mk(3'd7, 3'd0, 3'd0, 0, 1, 0,   0, 0, 3'd0, 0, 3);
        tbl[30] = mk(3'd7, 3'd0, 3'd0, 0, 1, 1,   0, 0, 3'd0, 0, 3);
        tbl[31] = mk(3'd5, 3'd2, 3'd0, 0, 0, 0,   0, 0, 3'd2, 0, 3);
        tbl[32] = mk(3'd5, 3'd0, 3'd0, 0, 0, 0,   0, 0, 3'd2, 0, 3);
        tbl[33] = mk(3'd5, 3'd0, 3'd0, 0, 0, 0,   0, 0, 3'd2, 0, 3);
        tbl[34] = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   1, 1, 3'd2, 1, 3);
        tbl[35] = mk(3'd7, 3'd0, 3'd2, 0, 0, 0,   0, 1, 3'd0, 0, 3);
        tbl[36] = mk(3'd7, 3'd0, 3'd0, 0, 0, 0,   0, 1, 3'd0, 0, 3);

        sif.svc_ready = 1'b0;
        sif.svc_done  = 1'b0;
        sif.svc_more  = 1'b0;
        driver_ok     = 1'b1;
        queue_enable  = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_state", snap(), want(0, 0, 3'd0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single notify, hold-off, coalescing, notify during service,
        // done-outside-BUSY, disabled queue, queue_reset during GRANT.
        for (int k = 0; k < 37; k++) begin
            step(1'b1, tbl[k].en, tbl[k].ntf, tbl[k].qrst, tbl[k].rdy,
                 tbl[k].done, tbl[k].more);
            cmp($sformatf("vec%0d", k), snap(),
                want(tbl[k].ev, tbl[k].eq, tbl[k].ep, tbl[k].eb, tbl[k].ec));
        end

        // driver_ok drop during BUSY: pending cleared, done still awaited,
        // clear beats the svc_more re-arm, no grants afterwards.
        step(1, 3'd7, 3'd5, 3'd0, 0, 0, 0);
        cmp("dok_notify", snap(), want(0, 1, 3'd5, 0, 3));
        step(1, 3'd7, 3'd0, 3'd0, 0, 0, 0);
        cmp("dok_grant", snap(), want(1, 2, 3'd5, 1, 3));
        step(1, 3'd7, 3'd0, 3'd0, 1, 0, 0);
        cmp("dok_accept", snap(), want(0, 2, 3'd1, 1, 3));
        step(0, 3'd7, 3'd0, 3'd0, 0, 0, 0);
        cmp("dok_drop", snap(), want(0, 2, 3'd0, 1, 3));
        step(0, 3'd7, 3'd0, 3'd0, 0, 0, 0);
        cmp("dok_wait", snap(), want(0, 2, 3'd0, 1, 3));
        step(0, 3'd7, 3'd0, 3'd0, 0, 1, 1);
        cmp("dok_done", snap(), want(0, 2, 3'd0, 0, 3));
        step(0, 3'd7, 3'd2, 3'd0, 0, 0, 0);
        cmp("dok_notify_dead", snap(), want(0, 2, 3'd0, 0, 3));
        step(1, 3'd7, 3'd0, 3'd0, 0, 0, 0);
        cmp("dok_quiet1", snap(), want(0, 2, 3'd0, 0, 3));
        step(1, 3'd7, 3'd0, 3'd0, 0, 0, 0);
        cmp("dok_quiet2", snap(), want(0, 2, 3'd0, 0, 3));

        // Asynchronous reset in the middle of a GRANT.
        step(1, 3'd7, 3'd2, 3'd0, 0, 0, 0);
        step(1, 3'd7, 3'd0, 3'd0, 0, 0, 0);
        cmp("arst_pre", snap(), want(1, 1, 3'd2, 1, 3));
        #2;
        rst_n = 1'b0;
        #1;
        cmp("arst_now", snap(), want(0, 0, 3'd0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin fairness from reset: all three re-armed on every done.
        step(1, 3'd7, 3'd7, 3'd0, 0, 0, 0);
        cmp("rr_notify", snap(), want(0, 0, 3'd7, 0, 0));
        for (int g = 0; g < 6; g++) begin
            int w;
            w = 0;
            while (!sif.svc_valid && w < 5) begin
                step(1, 3'd7, 3'd0, 3'd0, 0, 0, 0);
                w++;
            end
            cmp($sformatf("rr%0d_valid", g), 64'(sif.svc_valid), 64'd1);
            cmp($sformatf("rr%0d_qid", g), 64'(sif.svc_qid), 64'(g % 3));
            step(1, 3'd7, 3'd0, 3'd0, 1, 0, 0);
            step(1, 3'd7, 3'd0, 3'd0, 0, 1, 1);
            cmp($sformatf("rr%0d_rearm", g), 64'(pending), 64'd7);
        end
        cmp("rr_cnt", 64'(coalesced_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/virtio_notify_sched.md
Name: virtio_notify_sched

Overview:
- Per-virtqueue notification scheduler between the virtio CSR block and the ring-fetch engine.
- Latches queue-notify doorbells as pending bits and picks one eligible queue round-robin.
- Hands that queue to the fetch engine over a valid/ready grant, then waits for completion before the next grant.
- Re-arms a queue when the fetch engine reports it still has available descriptors.

Parameters:
- NUM_Q, 3, number of virtqueues scheduled.
- CNT_W, 32, width of the saturating coalesced-notify counter.

Ports:
- clk  in  1  block clock (CSR/DMA clock domain).
- rst_n  in  1  asynchronous active-low reset.
- driver_ok  in  1  device_status DRIVER_OK bit; low means device not live.
- queue_enable  in  NUM_Q  per-queue ready/enable from CSR.
- queue_notify_set  in  NUM_Q  one-cycle doorbell pulse per queue from the CSR queue_notify write.
- queue_reset  in  NUM_Q  one-cycle per-queue reset pulse.
- svc_valid  out  1  grant offered to the fetch engine.
- svc_qid  out  QID_W  granted queue index.
- svc_ready  in  1  fetch engine accepts the grant.
- svc_done  in  1  one-cycle pulse: service of svc_qid finished.
- svc_more  in  1  qualifies svc_done: avail ring still non-empty.
- pending  out  NUM_Q  current pending bits (debug/status).
- busy  out  1  a grant is outstanding (GRANT or BUSY state).
- coalesced_cnt  out  CNT_W  number of notifies that hit an already-pending queue; saturates at all-ones.

Behaviour:
- Reset values: svc_valid=0, svc_qid=0, pending=0, busy=0, coalesced_cnt=0; round-robin pointer last=NUM_Q-1 (queue 0 first); state=IDLE.
- Pending update, per queue i, applied each clock edge, highest priority first:
  - driver_ok low: clear.
  - queue_reset[i]: clear.
  - queue_notify_set[i]: set.
  - svc_done && svc_more && svc_qid==i: set.
  - Grant accepted (svc_valid && svc_ready) for i: clear.
  - Otherwise: hold.
- Consequence: a notify arriving during service, or in the same cycle as acceptance, leaves the queue pending.
- Eligibility: eligible[i] = pending[i] & queue_enable[i] & driver_ok. Disabled queues keep their pending bit but are never granted.
- Arbitration:
  - Search starts at last+1 and wraps modulo NUM_Q (wrap from NUM_Q-1 to 0).
  - `last` updates to the granted qid when the grant is accepted.
- FSM:
  - IDLE:
    - If any queue is eligible: register the winner into svc_qid, set svc_valid=1, go to GRANT.
    - Latency: a notify sampled at edge N gives pending at N+1 and svc_valid at N+2.
  - GRANT:
    - svc_valid and svc_qid are held stable until svc_ready.
    - On svc_ready: svc_valid=0, go to BUSY.
    - If driver_ok drops or queue_reset[svc_qid] pulses before acceptance: withdraw (svc_valid=0, last unchanged), go to IDLE.
  - BUSY:
    - Wait for svc_done, then go to IDLE. The earliest next grant is 1 cycle after done.
    - queue_reset or driver_ok low during BUSY does not abort; the block still waits for svc_done, and the pending clear wins over svc_more re-arm.
- busy = (state != IDLE).
- svc_done outside BUSY is ignored (no pending or state change).
- At most one grant is outstanding.
- coalesced_cnt increments by the number of i with queue_notify_set[i] & pending[i] in that cycle (0..NUM_Q), saturating. It is not cleared by driver_ok.
- Asynchronous reset mid-operation returns every register to its reset value immediately. The fetch engine must see svc_valid drop.

Decomposition:
- Package virtio_sched_pkg:
  - QID_W = $clog2(NUM_Q), with a minimum of 1.
  - State enum {IDLE, GRANT, BUSY}.
  - Default NUM_Q.
- One sub-module, virtio_rr_arb: a combinational round-robin picker.
  - Inputs: req[NUM_Q], last.
  - Outputs: gnt_vld, gnt_idx.
  - Reused later by the used-ring writeback scheduler.

Test Plan:
- Single notify: notify_set=3'b010 at cycle 10 with all queues enabled and driver_ok=1 -> svc_valid at cycle 12 with svc_qid=1. Hold svc_ready low 3 cycles -> svc_qid stays 1. svc_ready=1 -> pending=0, busy=1. svc_done with svc_more=0 -> back to IDLE.
- Round-robin fairness: notify all three queues together, complete each grant with svc_more=1 -> grant order 0,1,2,0,1,2. No queue is granted twice while another eligible queue waits.
- Coalescing: notify queue 2 three times while it is pending (before grant) -> exactly one grant, coalesced_cnt=2.
- Notify during service: grant queue 0 accepted, notify q0 during BUSY, svc_done with svc_more=0 -> q0 pending=1 and granted again.
- Disable and reset: q1 pending with queue_enable[1]=0 -> no grant and pending held. Enable it -> grant. Pulse queue_reset[1] during GRANT -> svc_valid drops next cycle, pending[1]=0, no grant follows.
- driver_ok drop and async reset: driver_ok=0 during BUSY -> all pending cleared, block still waits for svc_done, then no further grants. Assert rst_n=0 mid-GRANT -> svc_valid=0 immediately and coalesced_cnt=0.
